wb_stream_writer: RTL and testbench



---
 rtl/wb_pkg.sv | 19 +
 rtl/sync_fifo.sv | 74 +++++++
 rtl/wb_stream_writer.sv | 166 ++++++++++++++++
 tb/tb_wb_stream_writer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone stream writer.
//   wb_wr_state_t : controller FSM state encoding
//   DROP_CNT_W    : width of the saturating dropped-word counter
//   clog2_min1    : ceil(log2(n)), never less than 1 (for counter widths)
package wb_pkg;

  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } wb_wr_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a first-word fall-through head.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write strobe and data (ignored when full)
//   pop_i         : read strobe (ignored when empty)
//   rdata_o       : current head word, valid whenever empty is low
//   level         : occupancy, 0..DEPTH
//   full, empty   : occupancy flags, derived from the registered level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    do_push  = push_i && !full;
    do_pop   = pop_i && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/wb_stream_writer.sv
// Drains a valid/ready stream into single-beat Wishbone classic writes.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   s_valid_i/s_ready_o  : stream handshake; s_data_i is the word
//   cyc_o/stb_o/we_o     : Wishbone controller strobes (we_o fixed high)
//   dat_o                : write data, held stable for the whole request
//   ack_i/err_i/rty_i    : device responses (err > rty > ack)
//   dat_i                : read data, unused by a write-only controller
//   busy_o               : FIFO held words or a write was in progress
//   err_pulse_o          : one-cycle pulse per dropped word
//   drop_count_o         : saturating count of dropped words
//   level_o              : FIFO occupancy
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | cyc_o low; start a write as soon as the FIFO has a word
//   REQ   | cyc_o/stb_o high with the head word on dat_o; wait response
//   GAP   | cyc_o low for RETRY_GAP cycles after a retry, then reissue
module wb_stream_writer
  import wb_pkg::*;
#(
  parameter int DAT_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_RETRIES = 3,
  parameter int RETRY_GAP   = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DAT_WIDTH-1:0]          s_data_i,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [DAT_WIDTH-1:0]          dat_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  input  logic                          rty_i,
  input  logic [DAT_WIDTH-1:0]          dat_i,
  output logic                          busy_o,
  output logic                          err_pulse_o,
  output logic [DROP_CNT_W-1:0]         drop_count_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int RW = clog2_min1(MAX_RETRIES + 1);
  localparam int GW = clog2_min1(RETRY_GAP);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRIES);
  localparam logic [GW-1:0] GAP_LOAD = GW'(RETRY_GAP - 1);

  wb_wr_state_t            state_q, state_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [DAT_WIDTH-1:0]    dat_q, dat_d;
  logic                    cyc_q, cyc_d;
  logic                    err_pulse_q, err_pulse_d;
  logic                    busy_q, busy_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                    fifo_push, fifo_pop, drop;
  logic [DAT_WIDTH-1:0]    fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                    fifo_full, fifo_empty;
  logic                    unused_dat;

  assign unused_dat = ^dat_i;
  assign fifo_push  = s_valid_i && !fifo_full;

  sync_fifo #(
    .WIDTH (DAT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (s_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    gap_d    = gap_q;
    dat_d    = dat_q;
    fifo_pop = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = REQ;
          dat_d   = fifo_head;
        end
      end
      REQ: begin
        if (err_i) begin
          fifo_pop = 1'b1;
          drop     = 1'b1;
          state_d  = IDLE;
        end else if (rty_i) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 1'b1;
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            // retries exhausted: the word is abandoned like an error
            fifo_pop = 1'b1;
            drop     = 1'b1;
            state_d  = IDLE;
          end
        end else if (ack_i) begin
          fifo_pop = 1'b1;
          state_d  = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = REQ;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) retry_d = '0;

    // cyc is registered from the next state so it changes right after the edge
    cyc_d       = (state_d == REQ);
    err_pulse_d = drop;
    drop_cnt_d  = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    busy_d      = !fifo_empty || (state_q != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      gap_q       <= '0;
      dat_q       <= '0;
      cyc_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      dat_q       <= dat_d;
      cyc_q       <= cyc_d;
      err_pulse_q <= err_pulse_d;
      busy_q      <= busy_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign cyc_o        = cyc_q;
  assign stb_o        = cyc_q;
  assign we_o         = 1'b1;
  assign dat_o        = dat_q;
  assign busy_o       = busy_q;
  assign err_pulse_o  = err_pulse_q;
  assign drop_count_o = drop_cnt_q;
  assign level_o      = fifo_level;
  assign s_ready_o    = !fifo_full;

endmodule

// File: tb/tb_wb_stream_writer.sv
module tb_wb_stream_writer;
  import wb_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int MAXR  = 3;
  localparam int GAPN  = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic cyc, stb, we;
  logic [DW-1:0] dat_o, dat_i;
  logic ack, err, rty;
  logic busy, err_pulse;
  logic [DROP_CNT_W-1:0] drop_count;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  wb_stream_writer #(
    .DAT_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_RETRIES(MAXR), .RETRY_GAP(GAPN)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .dat_o(dat_o),
    .ack_i(ack), .err_i(err), .rty_i(rty), .dat_i(dat_i),
    .busy_o(busy), .err_pulse_o(err_pulse),
    .drop_count_o(drop_count), .level_o(level)
  );

  int total = 0;
  int bad   = 0;

  // reference model: words the controller owns, in issue order
  logic [DW-1:0] exp_q[$];
  int  m_lvl, m_gap, m_tries, m_drops;
  bit  m_cyc, m_pulse, m_busy;

  // device and stream stimulus controls
  logic [2:0]    script[$];   // {err, rty, ack}
  logic [DW-1:0] push_q[$];
  int  dev_mode;              // 0 = ack, 1 = random, 2 = always err
  int  dev_lat, hi_cnt, push_pct;
  bit  dev_stall, noise, rand_push;

  // observation statistics
  int  cyc_rises, cyc_hi, lvl_peak;
  bit  prev_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lvl = 0; m_gap = 0; m_tries = 0; m_drops = 0;
    m_cyc = 0; m_pulse = 0; m_busy = 0;
    hi_cnt = 0; prev_cyc = 0;
  endtask

  task automatic clear_stats();
    cyc_rises = 0; cyc_hi = 0; lvl_peak = 0;
  endtask

  task automatic check_outputs();
    check("cyc", cyc, m_cyc);
    check("stb", stb, m_cyc);
    check("we", we, 1);
    check("level", level, m_lvl);
    check("s_ready", s_ready, (m_lvl < DEPTH));
    check("busy", busy, m_busy);
    check("err_pulse", err_pulse, m_pulse);
    check("drop_count", drop_count, m_drops);
    if (m_cyc) begin
      if (exp_q.size() > 0) check("dat_o", dat_o, exp_q[0]);
      else                  check("model_word_present", exp_q.size(), 1);
    end
  endtask

  // advance the reference by one clock edge using the inputs just applied
  task automatic model_edge(output bit acc);
    bit fin, drp, retry, cyc_next, busy_next;
    acc = s_valid && (m_lvl < DEPTH);
    fin = 0; drp = 0; retry = 0;
    busy_next = (m_lvl > 0) || m_cyc || (m_gap > 0);
    if (m_cyc) begin
      if (err) begin
        fin = 1; drp = 1;
      end else if (rty) begin
        if (m_tries < MAXR) retry = 1;
        else begin fin = 1; drp = 1; end
      end else if (ack) begin
        fin = 1;
      end
    end
    if (m_cyc) cyc_next = !(fin || retry);
    else if (m_gap > 0) begin
      m_gap--;
      cyc_next = (m_gap == 0);
    end else cyc_next = (m_lvl > 0);
    if (retry) begin m_tries++; m_gap = GAPN; end
    if (fin) begin void'(exp_q.pop_front()); m_tries = 0; end
    if (acc) exp_q.push_back(s_data);
    m_lvl   = m_lvl + int'(acc) - int'(fin);
    m_pulse = drp;
    if (drp && m_drops < 255) m_drops++;
    m_busy  = busy_next;
    m_cyc   = cyc_next;
  endtask

  task automatic step();
    bit from_q, acc;
    logic [2:0] resp;
    int r;
    @(negedge clk);
    check_outputs();
    if (cyc) cyc_hi++;
    if (cyc && !prev_cyc) cyc_rises++;
    prev_cyc = cyc;
    if (int'(level) > lvl_peak) lvl_peak = int'(level);

    from_q = 0;
    s_valid = 0;
    s_data  = DW'($urandom);
    if (push_q.size() > 0) begin
      s_valid = 1; s_data = push_q[0]; from_q = 1;
    end else if (rand_push) begin
      s_valid = ($urandom_range(0, 99) < push_pct);
    end

    resp = 3'b000;
    if (cyc) begin
      if (hi_cnt == 0 && dev_mode == 1) dev_lat = $urandom_range(0, 3);
      if (!dev_stall && hi_cnt >= dev_lat) begin
        if (script.size() > 0) resp = script.pop_front();
        else if (dev_mode == 2) resp = 3'b100;
        else if (dev_mode == 1) begin
          r = $urandom_range(0, 9);
          case (r)
            6:       resp = 3'b010;
            7:       resp = 3'b011;
            8:       resp = 3'b100;
            9:       resp = 3'b111;
            default: resp = 3'b001;
          endcase
        end else resp = 3'b001;
      end
      hi_cnt++;
    end else begin
      hi_cnt = 0;
      if (noise) resp = 3'($urandom_range(0, 7));
    end
    {err, rty, ack} = resp;

    @(posedge clk);
    model_edge(acc);
    if (from_q && acc) void'(push_q.pop_front());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_lvl > 0 || m_cyc || m_gap > 0 || push_q.size() > 0) && n < 400) begin
      step();
      n++;
    end
    check("drain_timeout_level", m_lvl, 0);
    step();
    step();
  endtask

  initial begin
    rst_n = 0; s_valid = 0; s_data = '0; dat_i = '0;
    ack = 0; err = 0; rty = 0;
    dev_mode = 0; dev_lat = 0; dev_stall = 0; noise = 0;
    rand_push = 0; push_pct = 0;
    model_reset();
    clear_stats();

    #12;
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_busy", busy, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_level", level, 0);
    check("rst_dat_o", dat_o, 0);
    @(negedge clk);
    rst_n = 1;
    #1 check("ready_after_reset", s_ready, 1);

    // single word, ack in the first request cycle
    clear_stats();
    push_q.push_back(8'hA5);
    drain();
    check("single_cyc_cycles", cyc_hi, 1);
    check("single_rises", cyc_rises, 1);

    // back-to-back words with a slow device
    clear_stats();
    dev_lat = 2;
    for (int i = 1; i <= 4; i++) push_q.push_back(DW'(i));
    drain();
    check("b2b_rises", cyc_rises, 4);
    check("b2b_level_peak", lvl_peak, 4);
    dev_lat = 0;

    // retry twice then success
    clear_stats();
    script.push_back(3'b010);
    script.push_back(3'b010);
    script.push_back(3'b001);
    push_q.push_back(8'h3C);
    drain();
    check("retry_rises", cyc_rises, 3);
    check("retry_no_drop", drop_count, 0);

    // retry exhaustion, then the following word goes out
    clear_stats();
    repeat (4) script.push_back(3'b010);
    push_q.push_back(8'h77);
    push_q.push_back(8'h88);
    drain();
    check("exhaust_drops", drop_count, 1);
    check("exhaust_rises", cyc_rises, 5);

    // simultaneous ack and err counts as an error
    script.push_back(3'b101);
    push_q.push_back(8'h5A);
    drain();
    check("simul_drops", drop_count, 2);

    // overflow with the device stalled
    dev_stall = 1;
    for (int i = 0; i < DEPTH + 1; i++) push_q.push_back(DW'(8'hC0 + i));
    repeat (8) step();
    check("ovf_ready_low", s_ready, 0);
    check("ovf_level_full", level, DEPTH);
    push_q.delete();
    dev_stall = 0;
    drain();

    // asynchronous reset while a request is outstanding
    clear_stats();
    dev_stall = 1;
    for (int i = 0; i < 3; i++) push_q.push_back(DW'(8'hE0 + i));
    repeat (6) step();
    check("pre_reset_cyc", cyc, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_cyc", cyc, 0);
    check("async_rst_level", level, 0);
    check("async_rst_drops", drop_count, 0);
    check("async_rst_pulse", err_pulse, 0);
    push_q.delete();
    script.delete();
    model_reset();
    s_valid = 0; ack = 0; err = 0; rty = 0;
    dev_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    clear_stats();
    repeat (10) step();
    check("post_reset_no_writes", cyc_hi, 0);

    // randomized traffic with mixed responses and noise while idle
    dev_mode = 1; noise = 1; rand_push = 1; push_pct = 60;
    repeat (2500) step();
    rand_push = 0;
    drain();

    // constant errors to reach drop counter saturation
    dev_mode = 2; dev_lat = 0; rand_push = 1; push_pct = 100;
    repeat (700) step();
    rand_push = 0;
    drain();
    check("drop_saturated", drop_count, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
